sw_alloc5: RTL



---
 rtl/sw_alloc5.sv | 137 +++++++++++++
 1 files changed

// File: rtl/sw_alloc5.sv
// rtl/sw_alloc5.sv - 5-port switch allocator: per-output round-robin with wormhole locking
// Grants are combinational; allocVector is the registered crossbar select one cycle later.
module sw_alloc5 #(
  parameter int         NUM_CHANNEL = 5,
  parameter logic [2:0] RR_RESET    = 3'd0
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic [NUM_CHANNEL-1:0]             reqValid,
  input  logic [NUM_CHANNEL*NUM_CHANNEL-1:0] reqDest,
  input  logic [NUM_CHANNEL-1:0]             reqTail,
  input  logic [NUM_CHANNEL-1:0]             outReady,
  output logic [NUM_CHANNEL-1:0]             grant,
  output logic [NUM_CHANNEL*NUM_CHANNEL-1:0] allocVector,
  output logic                               destErr
);

  localparam int N = NUM_CHANNEL;

  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

  state_t [N-1:0]        state_q, state_d;
  logic   [N-1:0][2:0]   rr_ptr_q, rr_ptr_d;
  logic   [N-1:0][2:0]   lock_owner_q, lock_owner_d;

  logic   [N-1:0]        dest_ok;
  logic   [N-1:0][N-1:0] req_col;   // req_col[j][i]: input i eligible for output j
  logic   [N-1:0][3:0]   pick;      // {found, winner} of the round-robin search per output
  logic   [N-1:0][N-1:0] out_gnt;   // out_gnt[j][i]: output j grants input i
  logic   [N-1:0]        grant_any;
  logic   [N*N-1:0]      alloc_d;
  logic                  dest_bad;

  function automatic logic onehot5(input logic [N-1:0] d);
    return (d != '0) && ((d & (d - 1'b1)) == '0);
  endfunction

  function automatic logic [2:0] ptr_inc(input logic [2:0] p);
    return (p == 3'(N - 1)) ? 3'd0 : p + 3'd1;
  endfunction

  // Lowest-offset hit from ptr wins; scanning downward lets the first hit overwrite later ones.
  function automatic logic [3:0] rr_pick(input logic [N-1:0] req, input logic [2:0] ptr);
    logic [3:0] res;
    logic [3:0] sum;
    logic [2:0] idx;
    res = '0;
    for (int k = N - 1; k >= 0; k--) begin
      sum = {1'b0, ptr} + 4'(k);
      if (sum >= 4'(N)) sum = sum - 4'(N);
      idx = sum[2:0];
      if (req[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  always_comb begin
    dest_ok = '0;
    req_col = '0;
    for (int i = 0; i < N; i++) begin
      dest_ok[i] = onehot5(reqDest[i*N +: N]);
    end
    for (int j = 0; j < N; j++) begin
      for (int i = 0; i < N; i++) begin
        req_col[j][i] = reqValid[i] & reqDest[i*N + j] & outReady[j] & dest_ok[i];
      end
    end
  end

  always_comb begin
    pick = '0;
    for (int j = 0; j < N; j++) begin
      pick[j] = rr_pick(req_col[j], rr_ptr_q[j]);
    end
  end

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    lock_owner_d = lock_owner_q;
    out_gnt      = '0;
    for (int j = 0; j < N; j++) begin
      case (state_q[j])
        IDLE: begin
          if (pick[j][3]) begin
            out_gnt[j][pick[j][2:0]] = 1'b1;
            rr_ptr_d[j]              = ptr_inc(pick[j][2:0]);
            if (!reqTail[pick[j][2:0]]) begin
              state_d[j]      = LOCKED;
              lock_owner_d[j] = pick[j][2:0];
            end
          end
        end
        LOCKED: begin
          if (req_col[j][lock_owner_q[j]]) begin
            out_gnt[j][lock_owner_q[j]] = 1'b1;
            if (reqTail[lock_owner_q[j]]) state_d[j] = IDLE;
          end
        end
        default: state_d[j] = IDLE;
      endcase
    end
  end

  always_comb begin
    grant_any = '0;
    alloc_d   = '0;
    for (int j = 0; j < N; j++) begin
      for (int i = 0; i < N; i++) begin
        grant_any[i]     = grant_any[i] | out_gnt[j][i];
        alloc_d[i*N + j] = out_gnt[j][i];
      end
    end
  end

  assign dest_bad = |(reqValid & ~dest_ok);
  assign grant    = reset_n ? grant_any : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int j = 0; j < N; j++) begin
        state_q[j]      <= IDLE;
        rr_ptr_q[j]     <= RR_RESET;
        lock_owner_q[j] <= 3'd0;
      end
      allocVector <= '0;
      destErr     <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      lock_owner_q <= lock_owner_d;
      allocVector  <= alloc_d;
      destErr      <= destErr | dest_bad;
    end
  end

endmodule
